fetch_stage: RTL and testbench

Instruction-fetch (IF) stage of the 5-stage MIPS pipeline, with the IF/ID pipeline register. It holds the PC and drives the combinational instruction-memory read port. It latches the fetched word into IF/ID for the decode stage, and obeys stall, flush and redirect requests from the hazard/branch logic. It also exports `pc`, which the processor bench polls to detect program exit.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/if_id_reg.sv | 37 +++
 rtl/fetch_stage.sv | 151 +++++++++++++++
 tb/tb_fetch_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS pipeline front end.
//   NOP                 - all-zero instruction word (sll $0,$0,0)
//   TEXT_START_DEFAULT  - default reset PC / base of the instruction region
//   TEXT_BYTES_DEFAULT  - default size of the instruction region in bytes
//   fetch_state_t       - fetch FSM states (BOOT, RUN)
//   if_id_t             - contents of the IF/ID pipeline register
package mips_pkg;

  localparam logic [31:0] NOP                = 32'h0000_0000;
  localparam logic [31:0] TEXT_START_DEFAULT = 32'h0040_0000;
  localparam int unsigned TEXT_BYTES_DEFAULT = 1024;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: the IF/ID pipeline register.
//   clk, rst - clock and asynchronous active-high reset
//   bubble   - invalidate the entry and replace the word with NOP; the PC
//              fields keep their previous value
//   load     - capture d
//   d        - entry produced by the fetch stage this cycle
//   q        - entry presented to the decode stage
// Bubble has priority over load; with neither asserted the entry holds.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] TEXT_START = TEXT_START_DEFAULT
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   bubble,
  input  logic   load,
  input  if_id_t d,
  output if_id_t q
);

  // ---- IF/ID boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q.valid <= 1'b0;
      q.pc    <= TEXT_START;
      q.pc4   <= TEXT_START + 32'd4;
      q.instr <= NOP;
    end else if (bubble) begin
      q.valid <= 1'b0;
      q.instr <= NOP;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 5-stage MIPS pipeline.
//   clk, rst        - clock, asynchronous active-high reset
//   stall           - hold PC and IF/ID (load-use hazard)
//   flush           - turn IF/ID into a bubble on the next edge
//   redirect_valid  - take redirect_pc as the next PC, bubble IF/ID
//   redirect_pc     - branch/jump target
//   imem_addr       - instruction-memory byte address (always equals pc)
//   imem_rdata      - instruction word, combinational from imem_addr
//   pc              - current fetch PC
//   if_id_valid/pc/pc4/instr - IF/ID register contents for decode
//   fetch_fault     - sticky: an out-of-region or misaligned PC was fetched
//   fetch_count     - number of valid instructions loaded into IF/ID
//   stall_count     - number of RUN cycles with stall and no redirect
// The BOOT state spends its single cycle fetching TEXT_START unconditionally;
// hazard inputs are only honoured from RUN onward.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] TEXT_START = TEXT_START_DEFAULT,
  parameter int unsigned TEXT_BYTES = TEXT_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        fetch_fault,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic         fault_q;
  logic [31:0]  fetch_cnt_q;
  logic [31:0]  stall_cnt_q;

  logic         boot;
  logic         in_range_p0;
  logic [31:0]  pc4_p0;
  logic [31:0]  word_p0;
  logic         do_bubble;
  logic         do_load;
  logic         do_stall_cnt;
  logic [31:0]  pc_next;
  if_id_t       if_id_d;
  if_id_t       if_id_q;

  // Offset test wraps naturally, so addresses below TEXT_START give a huge
  // offset and fall outside the region without a separate lower-bound compare.
  function automatic logic pc_in_range(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - TEXT_START;
    return (addr[1:0] == 2'b00) && (off < TEXT_BYTES);
  endfunction

  // ---- IF stage (p0): address out, word back, next-PC select ----
  assign boot        = (state_q == BOOT);
  assign imem_addr   = pc_q;
  assign in_range_p0 = pc_in_range(pc_q);
  assign pc4_p0      = pc_q + 32'd4;
  assign word_p0     = in_range_p0 ? imem_rdata : NOP;

  always_comb begin
    do_bubble    = 1'b0;
    do_load      = 1'b0;
    do_stall_cnt = 1'b0;
    pc_next      = pc4_p0;
    if (boot) begin
      do_load = 1'b1;
    end else begin
      // IF/ID: flush/redirect bubble beats stall hold beats load.
      if (flush || redirect_valid) begin
        do_bubble = 1'b1;
      end else if (!stall) begin
        do_load = 1'b1;
      end
      // PC: redirect beats stall beats sequential.
      if (redirect_valid) begin
        pc_next = redirect_pc;
      end else if (stall) begin
        pc_next      = pc_q;
        do_stall_cnt = 1'b1;
      end
    end
  end

  always_comb begin
    if_id_d.valid = 1'b1;
    if_id_d.pc    = pc_q;
    if_id_d.pc4   = pc4_p0;
    if_id_d.instr = word_p0;
  end

  // ---- Control state: FSM, PC, fault flag, counters ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BOOT;
      pc_q        <= TEXT_START;
      fault_q     <= 1'b0;
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      case (state_q)
        BOOT:    state_q <= RUN;
        RUN:     state_q <= RUN;
        default: state_q <= BOOT;
      endcase
      pc_q <= pc_next;
      if (do_load && !in_range_p0) begin
        fault_q <= 1'b1;
      end
      if (do_load) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (do_stall_cnt) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  // ---- IF/ID boundary (p1) ----
  if_id_reg #(
    .TEXT_START(TEXT_START)
  ) u_if_id (
    .clk    (clk),
    .rst    (rst),
    .bubble (do_bubble),
    .load   (do_load),
    .d      (if_id_d),
    .q      (if_id_q)
  );

  assign pc          = pc_q;
  assign if_id_valid = if_id_q.valid;
  assign if_id_pc    = if_id_q.pc;
  assign if_id_pc4   = if_id_q.pc4;
  assign if_id_instr = if_id_q.instr;
  assign fetch_fault = fault_q;
  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios followed by randomized stall/flush/
// redirect/reset traffic, checked against a behavioural model of the fetch
// stage kept in this file.
module tb_fetch_stage;

  localparam logic [31:0] TS = 32'h0040_0000;
  localparam longint      TB_BYTES = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_rdata, pc;
  logic        if_id_valid, fetch_fault;
  logic [31:0] if_id_pc, if_id_pc4, if_id_instr, fetch_count, stall_count;

  logic [31:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  // model state
  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, m_fc, m_sc;
  logic        m_booting, m_valid, m_fault;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4),
    .if_id_instr(if_id_instr), .fetch_fault(fetch_fault),
    .fetch_count(fetch_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Instruction memory: region words from mem[], anything else returns a
  // nonzero junk word so NOP substitution is visible.
  always_comb begin
    logic [31:0] off;
    off = imem_addr - TS;
    if (off < 32'd1024) imem_rdata = mem[off[9:2]];
    else                imem_rdata = imem_addr ^ 32'hC3C3_0001;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit model_in_range(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(TS);
    return (off >= 0) && (off < TB_BYTES) && (a % 4 == 0);
  endfunction

  task automatic model_reset();
    m_pc = TS; m_booting = 1'b1; m_valid = 1'b0;
    m_ipc = TS; m_ipc4 = TS + 32'd4; m_instr = 32'h0;
    m_fault = 1'b0; m_fc = 32'd0; m_sc = 32'd0;
  endtask

  // One clock edge of the fetch stage, evaluated from the inputs present.
  task automatic model_edge();
    bit          inr;
    logic [31:0] word;
    bit          load;
    inr  = model_in_range(m_pc);
    word = inr ? mem[(m_pc - TS) / 4] : 32'h0;
    if (m_booting) begin
      load = 1'b1;
    end else begin
      load = !(flush || redirect_valid) && !stall;
      if (flush || redirect_valid) begin
        m_valid = 1'b0;
        m_instr = 32'h0;
      end
      if (stall && !redirect_valid) m_sc = m_sc + 1;
    end
    if (load) begin
      m_valid = 1'b1; m_ipc = m_pc; m_ipc4 = m_pc + 4; m_instr = word;
      m_fc = m_fc + 1;
      if (!inr) m_fault = 1'b1;
    end
    if (!m_booting && redirect_valid) m_pc = redirect_pc;
    else if (!m_booting && stall)     m_pc = m_pc;
    else                              m_pc = m_pc + 4;
    m_booting = 1'b0;
  endtask

  task automatic check_all();
    chk("pc", pc, m_pc);
    chk("imem_addr", imem_addr, m_pc);
    chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
    chk("if_id_pc", if_id_pc, m_ipc);
    chk("if_id_pc4", if_id_pc4, m_ipc4);
    chk("if_id_instr", if_id_instr, m_instr);
    chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
    chk("fetch_count", fetch_count, m_fc);
    chk("stall_count", stall_count, m_sc);
  endtask

  task automatic step(input logic s, input logic f, input logic r, input logic [31:0] rpc);
    stall = s; flush = f; redirect_valid = r; redirect_pc = rpc;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Reset pulse placed between clock edges.
  task automatic async_reset();
    stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("arst_state_boot_valid", {31'd0, if_id_valid}, 32'd0);
    #2 rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom() | 32'h1;
    for (int i = 0; i < 16; i++)  mem[i] = 32'h2008_0001;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    model_reset();
    #12;
    check_all();
    chk("reset_pc", pc, 32'h0040_0000);
    chk("reset_pc4", if_id_pc4, 32'h0040_0004);
    rst = 1'b0;

    // free run 5 edges
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("run5_pc", pc, 32'h0040_0014);
    chk("run5_fetch_count", fetch_count, 32'd5);
    chk("run5_instr", if_id_instr, 32'h2008_0001);

    // stall two edges
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("stall_pc_held", pc, 32'h0040_0014);
    chk("stall_ifid_pc_held", if_id_pc, 32'h0040_0010);
    chk("stall_count2", stall_count, 32'd2);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("resume_ifid_pc", if_id_pc, 32'h0040_0014);

    // redirect together with stall
    step(1'b1, 1'b0, 1'b1, 32'h0040_0020);
    chk("redir_pc", pc, 32'h0040_0020);
    chk("redir_bubble_valid", {31'd0, if_id_valid}, 32'd0);
    chk("redir_bubble_instr", if_id_instr, 32'h0);
    chk("redir_stall_count", stall_count, 32'd2);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("redir_target_loaded", if_id_pc, 32'h0040_0020);

    // flush alone
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("flush_valid", {31'd0, if_id_valid}, 32'd0);
    chk("flush_pc_adv", pc, 32'h0040_0028);

    // run past the end of the text region
    step(1'b0, 1'b0, 1'b1, 32'h0040_03F8);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("oor_pc", pc, 32'h0040_0410);
    chk("oor_instr_nop", if_id_instr, 32'h0);
    chk("oor_fault", {31'd0, fetch_fault}, 32'd1);

    // asynchronous reset mid-run
    async_reset();
    chk("arst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("arst_count", fetch_count, 32'd0);

    // misaligned redirect target
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0040_0002);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("misalign_instr", if_id_instr, 32'h0);
    chk("misalign_fault", {31'd0, fetch_fault}, 32'd1);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      int          r;
      logic [31:0] tgt;
      r = $urandom_range(0, 99);
      if (r == 99) begin
        async_reset();
      end else if (m_booting) begin
        step(1'b0, 1'b0, 1'b0, 32'h0);
      end else begin
        case ($urandom_range(0, 3))
          0:       tgt = $urandom();
          1:       tgt = TS + $urandom_range(0, 1023);
          2:       tgt = 32'hFFFF_FFF8;
          default: tgt = TS + 4 * $urandom_range(0, 255);
        endcase
        step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, r < 10, tgt);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
